bitserial_adder: RTL and testbench

BITSERIAL_ADDER -- requirements
Module: bitserial_adder

---
 rtl/bitserial_adder_pkg.sv | 21 ++
 rtl/bitserial_adder_if.sv | 28 ++
 rtl/bitserial_adder_fa_cell.sv | 14 +
 rtl/bitserial_adder.sv | 141 ++++++++++++++
 tb/tb_bitserial_adder.sv | 157 +++++++++++++++
 5 files changed

// File: rtl/bitserial_adder_pkg.sv
// Bit-serial adder shared definitions.
// Op encodings, FSM states and sizing helpers.
package bitserial_adder_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_ACC = 2'b10;
    localparam logic [1:0] OP_CLR = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_e;

    // Bits needed for a 0..w-1 bit counter.
    function automatic int cnt_bits(input int w);
        return (w > 2) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/bitserial_adder_if.sv
// Bit-serial adder request/result bundle.
// master drives requests and consumes results; slave is the adder.
interface bitserial_adder_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, op, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, op, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );

endinterface

// File: rtl/bitserial_adder_fa_cell.sv
// Single-bit full adder cell.
// The only arithmetic element in the serial datapath.
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ cin;
    assign co = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/bitserial_adder.sv
// Bit-serial add/sub/accumulate unit.
// One bit per cycle LSB-first through a single full-adder cell.
module bitserial_adder
    import bitserial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    bitserial_adder_if.slave   bus
);

    localparam int CW = cnt_bits(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_e           state;
    logic [1:0]       op_q;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] acc;
    logic [CW-1:0]    cnt;
    logic             carry;

    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    logic             fa_s;
    logic             fa_co;
    logic [WIDTH-1:0] res_next;

    fa_cell u_fa (
        .a   (a_sr[0]),
        .b   (b_sr[0]),
        .cin (carry),
        .s   (fa_s),
        .co  (fa_co)
    );

    // a_sr doubles as the result register: sum bits enter at the MSB.
    assign res_next = {fa_s, a_sr[WIDTH-1:1]};

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.sum       = sum;
    assign bus.cout      = cout;
    assign bus.ovf       = ovf;

    // Control FSM and serial datapath; all outputs registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            op_q      <= OP_ADD;
            a_sr      <= '0;
            b_sr      <= '0;
            acc       <= '0;
            cnt       <= '0;
            carry     <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        op_q     <= bus.op;
                        in_ready <= 1'b0;
                        state    <= RUN;
                        cnt      <= '0;
                        unique case (bus.op)
                            OP_ADD: begin
                                a_sr  <= bus.a;
                                b_sr  <= bus.b;
                                carry <= bus.cin;
                            end
                            OP_SUB: begin
                                a_sr  <= bus.a;
                                b_sr  <= ~bus.b;
                                carry <= 1'b1;
                            end
                            OP_ACC: begin
                                a_sr  <= acc;
                                b_sr  <= bus.a;
                                carry <= bus.cin;
                            end
                            default: begin
                                // Clear spends exactly one pass in RUN.
                                a_sr  <= '0;
                                b_sr  <= '0;
                                carry <= 1'b0;
                                cnt   <= LAST;
                            end
                        endcase
                    end
                end
                RUN: begin
                    a_sr  <= res_next;
                    b_sr  <= {1'b0, b_sr[WIDTH-1:1]};
                    carry <= fa_co;
                    cnt   <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        cnt       <= '0;
                        carry     <= 1'b0;
                        if (op_q == OP_CLR) begin
                            acc  <= '0;
                            sum  <= '0;
                            cout <= 1'b0;
                            ovf  <= 1'b0;
                        end else begin
                            sum  <= res_next;
                            cout <= fa_co;
                            ovf  <= fa_co ^ carry;
                            if (op_q == OP_ACC) begin
                                acc <= res_next;
                            end
                        end
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bitserial_adder.sv
// Directed bench for bitserial_adder at WIDTH=8.
// Hand-computed vectors checked with immediate assertions.
module tb_bitserial_adder;
    import bitserial_adder_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    int   lat;

    bitserial_adder_if #(.WIDTH(8)) bus ();

    bitserial_adder #(.WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start_op(input logic [1:0] op, input logic [7:0] a,
                            input logic [7:0] b, input logic cin);
        bus.op = op;
        bus.a = a;
        bus.b = b;
        bus.cin = cin;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        // Scramble inputs so any late sampling corrupts the result.
        bus.a = ~a;
        bus.b = ~b;
        bus.op = ~op;
        bus.cin = ~cin;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (bus.out_valid !== 1'b1 && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic consume(input string tag);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        chk({tag, "_ov_clr"}, 32'(bus.out_valid), 32'd0);
        chk({tag, "_rdy"}, 32'(bus.in_ready), 32'd1);
    endtask

    task automatic run_op(input string tag, input logic [1:0] op,
                          input logic [7:0] a, input logic [7:0] b,
                          input logic cin, input logic [7:0] esum,
                          input logic ecout, input logic eovf,
                          input int elat);
        int n;
        start_op(op, a, b, cin);
        wait_done(n);
        chk({tag, "_lat"}, 32'(n), 32'(elat));
        chk({tag, "_sum"}, 32'(bus.sum), 32'(esum));
        chk({tag, "_cout"}, 32'(bus.cout), 32'(ecout));
        chk({tag, "_ovf"}, 32'(bus.ovf), 32'(eovf));
        consume(tag);
        chk({tag, "_hold"}, 32'(bus.sum), 32'(esum));
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.op = OP_ADD;
        bus.a = '0;
        bus.b = '0;
        bus.cin = 1'b0;
        bus.out_ready = 1'b0;

        #12;
        chk("rst_rdy", 32'(bus.in_ready), 32'd1);
        chk("rst_ov", 32'(bus.out_valid), 32'd0);
        chk("rst_sum", 32'(bus.sum), 32'd0);
        chk("rst_cout", 32'(bus.cout), 32'd0);
        chk("rst_ovf", 32'(bus.ovf), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        run_op("add0f", OP_ADD, 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0, 8);
        run_op("addff", OP_ADD, 8'hFF, 8'h01, 1'b1, 8'h01, 1'b1, 1'b0, 8);
        run_op("add7f", OP_ADD, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 8);
        run_op("sub80", OP_SUB, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b1, 1'b1, 8);
        run_op("sub05", OP_SUB, 8'h05, 8'h03, 1'b1, 8'h02, 1'b1, 1'b0, 8);
        run_op("sub03", OP_SUB, 8'h03, 8'h05, 1'b0, 8'hFE, 1'b0, 1'b0, 8);

        run_op("clr", OP_CLR, 8'h55, 8'hAA, 1'b1, 8'h00, 1'b0, 1'b0, 1);
        run_op("acc10", OP_ACC, 8'h10, 8'h00, 1'b0, 8'h10, 1'b0, 1'b0, 8);
        run_op("acc20", OP_ACC, 8'h20, 8'h77, 1'b0, 8'h30, 1'b0, 1'b0, 8);
        run_op("accf0", OP_ACC, 8'hF0, 8'h00, 1'b0, 8'h20, 1'b1, 1'b0, 8);

        start_op(OP_ADD, 8'h01, 8'h02, 1'b0);
        wait_done(lat);
        chk("hold_lat", 32'(lat), 32'd8);
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = ~bus.in_valid;
            bus.a = 8'($urandom);
            bus.b = 8'($urandom);
            bus.op = 2'($urandom);
            @(posedge clk);
            #1;
            chk("hold_ov", 32'(bus.out_valid), 32'd1);
            chk("hold_rdy", 32'(bus.in_ready), 32'd0);
            chk("hold_sum", 32'(bus.sum), 32'h03);
            chk("hold_cout", 32'(bus.cout), 32'd0);
            chk("hold_ovf", 32'(bus.ovf), 32'd0);
        end
        bus.in_valid = 1'b0;
        consume("hold");
        repeat (3) @(posedge clk);
        #1;
        chk("noq_ov", 32'(bus.out_valid), 32'd0);
        chk("noq_rdy", 32'(bus.in_ready), 32'd1);

        start_op(OP_ACC, 8'h33, 8'h00, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("mrst_ov", 32'(bus.out_valid), 32'd0);
        chk("mrst_sum", 32'(bus.sum), 32'd0);
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("mrst_rdy", 32'(bus.in_ready), 32'd1);
        chk("mrst_ov2", 32'(bus.out_valid), 32'd0);
        run_op("acc05", OP_ACC, 8'h05, 8'h00, 1'b0, 8'h05, 1'b0, 1'b0, 8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
